// File: rtl/logic_decode_stage.sv
// logic_decode_stage: MIPS logic-op decode into a 2-entry skid FIFO; LOGIC_DECODE_STATS_EN adds a delivered-logic-op counter
module logic_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  func,
  output logic        logic_en,
  output logic        imm_sel,
  output logic [15:0] stat_count
);
  logic [5:0] dec, head;
  logic [5:0] mem_q [2];
  logic [5:0] mem_d [2];
  logic       wr_q, wr_d, rd_q, rd_d, acc, dlv;
  logic [1:0] cnt_q, cnt_d;
  logic       r_and, r_or, r_xor, r_nor, i_and, i_or, i_xor;
  assign r_and = opcode == 6'h00 && funct == 6'h24;
  assign r_or  = opcode == 6'h00 && funct == 6'h25;
  assign r_xor = opcode == 6'h00 && funct == 6'h26;
  assign r_nor = opcode == 6'h00 && funct == 6'h27;
  assign i_and = opcode == 6'h0C;
  assign i_or  = opcode == 6'h0D;
  assign i_xor = opcode == 6'h0E;
  // decode at the input into the stored form {func, logic_en, imm_sel}
  always_comb
    dec = (r_and || i_and) ? {4'b1000, 1'b1, i_and} :
          (r_or  || i_or)  ? {4'b1110, 1'b1, i_or}  :
          (r_xor || i_xor) ? {4'b0110, 1'b1, i_xor} :
          r_nor            ? {4'b0000, 1'b1, 1'b0}  : {4'b0010, 1'b0, 1'b0};
  assign head      = mem_q[rd_q];
  assign out_valid = cnt_q != 2'd0;
  assign in_ready  = !cnt_q[1];
  assign acc       = in_valid && in_ready;
  assign dlv       = out_valid && out_ready;
  assign func      = out_valid ? head[5:2] : 4'b0010;
  assign logic_en  = out_valid && head[1];
  assign imm_sel   = out_valid && head[0];
  // FIFO next state; flush wins over any same-cycle accept or deliver
  always_comb begin
    wr_d  = flush ? 1'b0 : wr_q ^ acc;
    rd_d  = flush ? 1'b0 : rd_q ^ dlv;
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, acc} - {1'b0, dlv};
    mem_d = mem_q;
    if (acc && !flush) mem_d[wr_q] = dec;
  end
  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
`ifdef LOGIC_DECODE_STATS_EN
  logic [15:0] stat_q, stat_d;
  // count delivered logic ops, saturating
  always_comb stat_d = (dlv && !flush && head[1] && stat_q != 16'hFFFF) ? stat_q + 16'd1 : stat_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stat_q <= 16'h0000;
    else stat_q <= stat_d;
  assign stat_count = stat_q;
`else
  assign stat_count = 16'h0000;
`endif
endmodule

// File: doc/logic_decode_stage.md
LOGIC_DECODE_STAGE -- requirements
Module: logic_decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  upstream instruction fields valid.
REQ-004 in_ready  output  1  stage can accept a beat this cycle.
REQ-005 opcode  input  6  MIPS opcode field [31:26].
REQ-006 funct  input  6  MIPS funct field [5:0].
REQ-007 flush  input  1  discard all held beats.
REQ-008 out_valid  output  1  decoded beat available at head.
REQ-009 out_ready  input  1  downstream (EX logic unit) accepts head beat.
REQ-010 func  output  4  logic-unit select; func[3:1] drives the logic mux, func[0] always 0.
REQ-011 logic_en  output  1  head beat is a logic op.
REQ-012 imm_sel  output  1  B operand = zero-extended immediate.
REQ-013 stat_count  output  16  logic ops delivered (see Configuration).

Function
REQ-014 Decode: op 0x00 with funct 0x24 AND -> func 4'b1000; 0x25 OR -> 4'b1110; 0x26 XOR -> 4'b0110; 0x27 NOR -> 4'b0000; all four: logic_en=1, imm_sel=0.
REQ-015 Decode: op 0x0C ANDI -> 4'b1000; 0x0D ORI -> 4'b1110; 0x0E XORI -> 4'b0110; all three: logic_en=1, imm_sel=1.
REQ-016 Any other opcode/funct combination -> func 4'b0010 (pass A), logic_en=0, imm_sel=0; beat still delivered.
REQ-017 Decoding is applied at acceptance; the 2-entry FIFO (skid buffer) stores decoded fields only.
REQ-018 Accept = in_valid & in_ready; deliver = out_valid & out_ready.
REQ-019 in_ready = (occupancy < 2), registered-state derived, no combinational path from out_ready.
REQ-020 Latency: a beat accepted in cycle N appears at the head with out_valid=1 in cycle N+1 at the earliest.
REQ-021 FIFO order is strict; simultaneous accept and deliver at occupancy 1 or 2 keeps occupancy unchanged.
REQ-022 At occupancy 2, in_ready=0; in_valid is ignored and no data is lost.
REQ-023 func/logic_en/imm_sel hold stable while out_valid=1 and out_ready=0.
REQ-024 When out_valid=0, func=4'b0010, logic_en=0, imm_sel=0.
REQ-025 flush has priority: the next cycle has occupancy 0, out_valid=0, in_ready=1; any same-cycle accept and deliver are cancelled, and the stat counter does not increment.
REQ-026 FIFO pointers are 1 bit each and wrap modulo 2; occupancy is a 2-bit count, 0..2.

Reset
REQ-027 On rst_n low, asynchronously: occupancy 0, pointers 0, out_valid=0, in_ready=1, func=4'b0010, logic_en=0, imm_sel=0, stat_count=0.
REQ-028 Reset mid-transfer discards held beats; the first rising clk edge after rst_n deasserts may accept a beat.

Configuration
REQ-029 Macro LOGIC_DECODE_STATS_EN defined: stat_count increments by 1 on each deliver with logic_en=1 and no flush, saturating at 16'hFFFF.
REQ-030 Macro LOGIC_DECODE_STATS_EN not defined: stat_count is tied to 16'h0000 and no counter register is built.

Verification
REQ-031 rst_n low, then high; send op 0x00 funct 0x25 with out_ready=1 -> next cycle out_valid=1, func=4'b1110, logic_en=1, imm_sel=0.
REQ-032 Send ANDI, ORI, XORI back-to-back with out_ready=0 -> in_ready drops to 0 after the 2nd beat; the 3rd beat is held upstream; release out_ready -> funcs arrive in order 1000, 1110, 0110, all with imm_sel=1.
REQ-033 Send op 0x23 (LW) -> delivered with func=4'b0010 and logic_en=0; stat_count unchanged.
REQ-034 Occupancy 2 plus flush while in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
REQ-035 With LOGIC_DECODE_STATS_EN defined and stat_count preloaded to 16'hFFFE by forcing, deliver 3 NOR -> final value 16'hFFFF; with the macro undefined, stat_count stays 0.
REQ-036 Assert rst_n low asynchronously between clk edges while occupancy is 1 -> out_valid=0 immediately, without waiting for a clock edge.
